// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle MIPS sequencer and the control unit:
// sequencer state encoding, pc_control codes and the branch offset helper.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_WRITEBACK,
    ST_HALTED
  } state_t;

  localparam logic [3:0] PC_SEQ    = 4'd0;
  localparam logic [3:0] PC_JUMP   = 4'd1;
  localparam logic [3:0] PC_JR     = 4'd2;
  localparam logic [3:0] PC_BRANCH = 4'd3;

  // Sign-extended 16-bit immediate, shifted to a byte offset (word aligned)
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/cpu_next_pc.sv
// Combinational next-PC selection: sequential, jump, jump-register and taken branch.
// Unknown pc_control codes fall back to sequential.
module cpu_next_pc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] ir,
  input  logic [31:0] rs_data,
  input  logic [3:0]  pc_control,
  output logic [31:0] next_pc
);

  logic [31:0] pc4;

  assign pc4 = pc + 32'd4;

  // Select the address of the next instruction; all additions wrap silently
  always_comb begin
    next_pc = pc4;
    case (pc_control)
      PC_JUMP:   next_pc = {pc4[31:28], 28'(ir << 2)};
      PC_JR:     next_pc = rs_data & 32'hFFFF_FFFC;
      PC_BRANCH: next_pc = pc4 + branch_offset(ir[15:0]);
      default:   next_pc = pc4;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multicycle sequencer for the simplified MIPS datapath. Owns PC and IR,
// steps each instruction through FETCH/DECODE/EXECUTE/[MEM]/WRITEBACK and
// gates the control unit's write enables so state commits in one cycle.
// Optional performance counters: define SEQ_PERF_COUNT_EN.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  input  logic [3:0]  pc_control,
  input  logic [31:0] rs_data,
  input  logic        mem_op,
  input  logic        reg_file_wren_in,
  input  logic [3:0]  data_mem_wren_in,
  output logic        reg_file_wren,
  output logic [3:0]  data_mem_wren,
  output logic        dmem_req,
  input  logic        dmem_ready,
  output logic        retired,
  output logic        halted
`ifdef SEQ_PERF_COUNT_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
`endif
);

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] next_pc;
  logic        active;

  cpu_next_pc u_next_pc (
    .pc         (pc_q),
    .ir         (ir_q),
    .rs_data    (rs_data),
    .pc_control (pc_control),
    .next_pc    (next_pc)
  );

  // Sequencer FSM with PC and IR; halt is only looked at in WRITEBACK so
  // in-flight fetches and data accesses always complete
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
      pc_q  <= RESET_PC;
      ir_q  <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_ready) begin
            ir_q  <= imem_rdata;
            state <= ST_DECODE;
          end
        end
        ST_DECODE:  state <= ST_EXECUTE;
        ST_EXECUTE: state <= mem_op ? ST_MEM : ST_WRITEBACK;
        ST_MEM: begin
          if (dmem_ready) state <= ST_WRITEBACK;
        end
        ST_WRITEBACK: begin
          pc_q  <= next_pc;
          state <= halt ? ST_HALTED : ST_FETCH;
        end
        ST_HALTED: begin
          if (!halt) state <= ST_FETCH;
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

  // Outputs decode the state register but are forced quiet while rst is
  // high, so a pending access drops in the same cycle reset is raised
  assign active        = !rst;
  assign pc            = active ? pc_q : RESET_PC;
  assign imem_addr     = pc;
  assign instruction   = active ? ir_q : '0;
  assign imem_req      = active && (state == ST_FETCH);
  assign dmem_req      = active && (state == ST_MEM);
  assign retired       = active && (state == ST_WRITEBACK);
  assign halted        = active && (state == ST_HALTED);
  assign reg_file_wren = retired && reg_file_wren_in;
  assign data_mem_wren = dmem_req ? data_mem_wren_in : '0;

`ifdef SEQ_PERF_COUNT_EN
  logic [31:0] cycle_q;
  logic [31:0] instr_q;

  // Free-running cycle and retired-instruction counters, paused while halted
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      if (state != ST_HALTED)   cycle_q <= cycle_q + 32'd1;
      if (state == ST_WRITEBACK) instr_q <= instr_q + 32'd1;
    end
  end

  assign cycle_count = active ? cycle_q : '0;
  assign instr_count = active ? instr_q : '0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer.
module tb_cpu_sequencer;

  logic        clk;
  logic        rst;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [3:0]  pc_control;
  logic [31:0] rs_data;
  logic        mem_op;
  logic        reg_file_wren_in;
  logic [3:0]  data_mem_wren_in;
  logic        reg_file_wren;
  logic [3:0]  data_mem_wren;
  logic        dmem_req;
  logic        dmem_ready;
  logic        retired;
  logic        halted;
`ifdef SEQ_PERF_COUNT_EN
  logic [31:0] cycle_count;
  logic [31:0] instr_count;
`endif

  int checks = 0;
  int errors = 0;

  cpu_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .rst              (rst),
    .halt             (halt),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_rdata       (imem_rdata),
    .instruction      (instruction),
    .pc               (pc),
    .pc_control       (pc_control),
    .rs_data          (rs_data),
    .mem_op           (mem_op),
    .reg_file_wren_in (reg_file_wren_in),
    .data_mem_wren_in (data_mem_wren_in),
    .reg_file_wren    (reg_file_wren),
    .data_mem_wren    (data_mem_wren),
    .dmem_req         (dmem_req),
    .dmem_ready       (dmem_ready),
    .retired          (retired),
    .halted           (halted)
`ifdef SEQ_PERF_COUNT_EN
    ,
    .cycle_count      (cycle_count),
    .instr_count      (instr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one non-memory instruction from FETCH; returns cycles to retire (-1 if never)
  task automatic exec_instr(input logic [31:0] word, input logic [3:0] pcc,
                            input logic [31:0] rs, output int cycles);
    cycles           = -1;
    imem_rdata       = word;
    pc_control       = pcc;
    rs_data          = rs;
    mem_op           = 1'b0;
    reg_file_wren_in = 1'b1;
    data_mem_wren_in = 4'b0000;
    for (int c = 1; c <= 20; c++) begin
      if (retired === 1'b1) begin
        cycles = c;
        step();
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; halt = 1'b0; imem_ready = 1'b1; imem_rdata = '0;
    pc_control = 4'd0; rs_data = '0; mem_op = 1'b0;
    reg_file_wren_in = 1'b0; data_mem_wren_in = 4'b0000; dmem_ready = 1'b1;
    step();
    step();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_ir: got %h want %h", instruction, 32'h0); end
    checks++; if ({imem_req, dmem_req, retired, halted, reg_file_wren} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want %b", {imem_req, dmem_req, retired, halted, reg_file_wren}, 5'b0);
    end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_rtype();
    imem_rdata = 32'h012A_4020; reg_file_wren_in = 1'b1; mem_op = 1'b0; pc_control = 4'd0;
    for (int c = 1; c <= 4; c++) begin
      checks++; if (imem_req !== (c == 1)) begin errors++; $display("FAIL rtype_imem_req c%0d: got %b want %b", c, imem_req, (c == 1)); end
      checks++; if (retired !== (c == 4)) begin errors++; $display("FAIL rtype_retired c%0d: got %b want %b", c, retired, (c == 4)); end
      checks++; if (reg_file_wren !== (c == 4)) begin errors++; $display("FAIL rtype_rf_wren c%0d: got %b want %b", c, reg_file_wren, (c == 4)); end
      if (c == 1) begin
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rtype_imem_addr: got %h want %h", imem_addr, 32'h0); end
      end
      if (c == 2) begin
        checks++; if (instruction !== 32'h012A_4020) begin errors++; $display("FAIL rtype_ir: got %h want %h", instruction, 32'h012A_4020); end
      end
      step();
    end
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL rtype_pc: got %h want %h", pc, 32'h4); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rtype_refetch: got %b want 1", imem_req); end
  endtask

  task automatic test_store();
    logic exp_mem;
    imem_rdata = 32'hAC43_0008; mem_op = 1'b1; data_mem_wren_in = 4'b1111;
    reg_file_wren_in = 1'b0; dmem_ready = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      exp_mem = (c >= 4) && (c <= 6);
      dmem_ready = (c >= 6);
      #1;
      checks++; if (dmem_req !== exp_mem) begin errors++; $display("FAIL store_dmem_req c%0d: got %b want %b", c, dmem_req, exp_mem); end
      checks++; if (data_mem_wren !== (exp_mem ? 4'b1111 : 4'b0000)) begin
        errors++; $display("FAIL store_wren c%0d: got %b want %b", c, data_mem_wren, (exp_mem ? 4'b1111 : 4'b0000));
      end
      checks++; if (retired !== (c == 7)) begin errors++; $display("FAIL store_retired c%0d: got %b want %b", c, retired, (c == 7)); end
      step();
    end
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL store_pc: got %h want %h", pc, 32'h8); end
    mem_op = 1'b0; data_mem_wren_in = 4'b0000; dmem_ready = 1'b1;
  endtask

  task automatic test_branch();
    int cyc;
    exec_instr(32'h0800_0040, 4'd1, 32'h0, cyc);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL jump_latency: got %0d want 4", cyc); end
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL jump_pc: got %h want %h", pc, 32'h100); end
    exec_instr(32'h1000_FFFF, 4'd3, 32'h0, cyc);
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL branch_pc: got %h want %h", pc, 32'h100); end
  endtask

  task automatic test_jr_wrap();
    int cyc;
    exec_instr(32'h0060_0008, 4'd2, 32'h0000_2003, cyc);
    checks++; if (pc !== 32'h0000_2000) begin errors++; $display("FAIL jr_pc: got %h want %h", pc, 32'h0000_2000); end
    exec_instr(32'h0060_0008, 4'd2, 32'hFFFF_FFFC, cyc);
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL jr_high_pc: got %h want %h", pc, 32'hFFFF_FFFC); end
    exec_instr(32'h012A_4020, 4'd0, 32'h0, cyc);
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h want %h", pc, 32'h0); end
    exec_instr(32'h012A_4020, 4'd7, 32'h0000_5550, cyc);
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL other_code_pc: got %h want %h", pc, 32'h4); end
  endtask

  task automatic test_halt();
    imem_rdata = 32'h012A_4020; pc_control = 4'd0; mem_op = 1'b0;
    halt = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin
        checks++; if (retired !== 1'b1) begin errors++; $display("FAIL halt_retire: got %b want 1", retired); end
      end
      step();
    end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_enter: got %b want 1", halted); end
    checks++; if ({imem_req, retired} !== 2'b00) begin errors++; $display("FAIL halt_quiet: got %b want 00", {imem_req, retired}); end
    step(); step(); step();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_hold: got %b want 1", halted); end
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL halt_pc: got %h want %h", pc, 32'h8); end
    halt = 1'b0;
    step();
    checks++; if ({halted, imem_req} !== 2'b01) begin errors++; $display("FAIL halt_resume: got %b want 01", {halted, imem_req}); end
  endtask

  task automatic test_reset_mid_mem();
    int cyc;
    mem_op = 1'b1; dmem_ready = 1'b0; data_mem_wren_in = 4'b0011;
    step(); step(); step();
    checks++; if ({dmem_req, data_mem_wren} !== 5'b10011) begin
      errors++; $display("FAIL mid_mem_active: got %b want %b", {dmem_req, data_mem_wren}, 5'b10011);
    end
    rst = 1'b1;
    #1;
    checks++; if ({dmem_req, data_mem_wren} !== 5'b0) begin
      errors++; $display("FAIL mid_rst_drop: got %b want %b", {dmem_req, data_mem_wren}, 5'b0);
    end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL mid_rst_pc: got %h want %h", pc, 32'h0); end
    step();
    checks++; if ({imem_req, dmem_req} !== 2'b00) begin errors++; $display("FAIL mid_rst_hold: got %b want 00", {imem_req, dmem_req}); end
`ifdef SEQ_PERF_COUNT_EN
    checks++; if ({cycle_count, instr_count} !== 64'h0) begin
      errors++; $display("FAIL mid_rst_counters: got %h/%h want 0/0", cycle_count, instr_count);
    end
`endif
    rst = 1'b0; mem_op = 1'b0; dmem_ready = 1'b1; data_mem_wren_in = 4'b0000;
    #1;
    checks++; if ({imem_req, pc} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL mid_rst_restart: got %b/%h want 1/%h", imem_req, pc, 32'h0);
    end
    exec_instr(32'h012A_4020, 4'd0, 32'h0, cyc);
    checks++; if (cyc !== 4 || pc !== 32'h4) begin
      errors++; $display("FAIL mid_rst_first_instr: got %0d/%h want 4/%h", cyc, pc, 32'h4);
    end
`ifdef SEQ_PERF_COUNT_EN
    checks++; if (cycle_count !== 32'd4) begin errors++; $display("FAIL cycle_count: got %0d want 4", cycle_count); end
    checks++; if (instr_count !== 32'd1) begin errors++; $display("FAIL instr_count: got %0d want 1", instr_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_store();
    test_branch();
    test_jr_wrap();
    test_halt();
    test_reset_mid_mem();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
